// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch allocates at the tail, execution marks entries
// done out of order, and the head retires one entry per cycle once it is done.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif

module rob_entry #(
    parameter int PHYSICAL_REG_NUM_WIDTH = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_i,
    input  logic                              alloc_hit_i,
    input  logic                              alloc_wr_i,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_i,
    input  logic                              wb_hit_i,
    input  logic                              commit_hit_i,
    output logic                              valid_o,
    output logic                              done_o,
    output logic                              wr_o,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] phy_o
);
    logic                              valid_q, valid_d;
    logic                              done_q, done_d;
    logic                              wr_q, wr_d;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] phy_q, phy_d;

    // Alloc only targets a free slot and commit only the occupied head, so the two
    // never collide; a writeback to a free slot must not leave a stale done bit.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        wr_d    = wr_q;
        phy_d   = phy_q;
        if (flush_i) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if (commit_hit_i) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
            wr_d    = 1'b0;
            phy_d   = '0;
        end else if (alloc_hit_i) begin
            valid_d = 1'b1;
            done_d  = 1'b0;
            wr_d    = alloc_wr_i;
            phy_d   = alloc_phy_i;
        end else if (wb_hit_i && valid_q) begin
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            phy_q   <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            phy_q   <= phy_d;
        end
    end

    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign wr_o    = wr_q;
    assign phy_o   = phy_q;
endmodule

module reorder_buffer #(
    parameter int ROB_DEPTH_WIDTH        = 4,
    parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_valid,
    input  logic                              alloc_with_write,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_wr_reg,
    output logic                              alloc_ready,
    output logic [ROB_DEPTH_WIDTH-1:0]        alloc_rob_id,
    input  logic                              wb_valid,
    input  logic [ROB_DEPTH_WIDTH-1:0]        wb_rob_id,
    input  logic                              flush,
    output logic                              commit_valid,
    output logic                              commit_with_write,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
    output logic                              rob_empty,
    output logic                              rob_full
);
    localparam int ENTRIES = 1 << ROB_DEPTH_WIDTH;

    logic [ROB_DEPTH_WIDTH-1:0] head_q, head_d;
    logic [ROB_DEPTH_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_DEPTH_WIDTH:0]   count_q, count_d;

    logic [ENTRIES-1:0]                             ent_valid;
    logic [ENTRIES-1:0]                             ent_done;
    logic [ENTRIES-1:0]                             ent_wr;
    logic [ENTRIES-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] ent_phy;

    logic alloc_fire;

    assign rob_full     = (count_q == (ROB_DEPTH_WIDTH+1)'(ENTRIES));
    assign rob_empty    = (count_q == '0);
    assign alloc_ready  = !rob_full;
    assign alloc_rob_id = tail_q;
    assign alloc_fire   = alloc_valid && alloc_ready;

    assign commit_valid         = ent_valid[head_q] && ent_done[head_q];
    assign commit_with_write    = commit_valid && ent_wr[head_q];
    assign commited_wr_register = commit_with_write ? ent_phy[head_q] : '0;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        rob_entry #(.PHYSICAL_REG_NUM_WIDTH(PHYSICAL_REG_NUM_WIDTH)) u_ent (
            .clk          (clk),
            .reset        (reset),
            .flush_i      (flush),
            .alloc_hit_i  (alloc_fire && (tail_q == ROB_DEPTH_WIDTH'(g))),
            .alloc_wr_i   (alloc_with_write),
            .alloc_phy_i  (alloc_phy_wr_reg),
            .wb_hit_i     (wb_valid && (wb_rob_id == ROB_DEPTH_WIDTH'(g))),
            .commit_hit_i (commit_valid && (head_q == ROB_DEPTH_WIDTH'(g))),
            .valid_o      (ent_valid[g]),
            .done_o       (ent_done[g]),
            .wr_o         (ent_wr[g]),
            .phy_o        (ent_phy[g])
        );
    end

    // Pointers wrap naturally at their width; flush wins over everything else.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire)   tail_d = tail_q + 1'b1;
            if (commit_valid) head_d = head_q + 1'b1;
            if (alloc_fire && !commit_valid)      count_d = count_q + 1'b1;
            else if (!alloc_fire && commit_valid) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: retire order, full/wrap, no-write commits,
// writeback latency, flush and asynchronous reset.
module tb_reorder_buffer;
    localparam int RW = 4;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_valid, alloc_with_write;
    logic [PW-1:0] alloc_phy_wr_reg;
    logic          alloc_ready;
    logic [RW-1:0] alloc_rob_id;
    logic          wb_valid;
    logic [RW-1:0] wb_rob_id;
    logic          flush;
    logic          commit_valid, commit_with_write;
    logic [PW-1:0] commited_wr_register;
    logic          rob_empty, rob_full;

    int n_cmp = 0;
    int n_err = 0;

    reorder_buffer #(.ROB_DEPTH_WIDTH(RW), .PHYSICAL_REG_NUM_WIDTH(PW)) dut (
        .clk                  (clk),
        .reset                (reset),
        .alloc_valid          (alloc_valid),
        .alloc_with_write     (alloc_with_write),
        .alloc_phy_wr_reg     (alloc_phy_wr_reg),
        .alloc_ready          (alloc_ready),
        .alloc_rob_id         (alloc_rob_id),
        .wb_valid             (wb_valid),
        .wb_rob_id            (wb_rob_id),
        .flush                (flush),
        .commit_valid         (commit_valid),
        .commit_with_write    (commit_with_write),
        .commited_wr_register (commited_wr_register),
        .rob_empty            (rob_empty),
        .rob_full             (rob_full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_with_write = 1'b0; alloc_phy_wr_reg = '0;
        wb_valid = 1'b0; wb_rob_id = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc(input logic wr, input logic [PW-1:0] phy);
        alloc_valid = 1'b1; alloc_with_write = wr; alloc_phy_wr_reg = phy;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic wb(input logic [RW-1:0] id);
        wb_valid = 1'b1; wb_rob_id = id;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #3;
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL reset_cv: got %b want 0", commit_valid); end
        n_cmp++; if (commit_with_write !== 1'b0) begin n_err++; $display("FAIL reset_cww: got %b want 0", commit_with_write); end
        n_cmp++; if (commited_wr_register !== 6'd0) begin n_err++; $display("FAIL reset_reg: got %0d want 0", commited_wr_register); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
        n_cmp++; if (alloc_rob_id !== 4'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", alloc_rob_id); end
        n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", rob_empty); end
        n_cmp++; if (rob_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", rob_full); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_in_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (alloc_rob_id !== 4'(i)) begin n_err++; $display("FAIL io_alloc_id: got %0d want %0d", alloc_rob_id, i); end
            alloc(1'b1, 6'(33 + i));
        end
        wb(4'd2);
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL io_nocommit_wb2: got %b want 0", commit_valid); end
        wb(4'd1);
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL io_nocommit_wb1: got %b want 0", commit_valid); end
        wb_valid = 1'b1; wb_rob_id = 4'd0;
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL io_nobypass: got %b want 0", commit_valid); end
        tick();
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL io_cv%0d: got %b want 1", i, commit_valid); end
            n_cmp++; if (commited_wr_register !== 6'(33 + i)) begin n_err++; $display("FAIL io_reg%0d: got %0d want %0d", i, commited_wr_register, 33 + i); end
            tick();
        end
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL io_after_cv: got %b want 0", commit_valid); end
        n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL io_empty: got %b want 1", rob_empty); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rob_full !== 1'b0) begin n_err++; $display("FAIL fw_notfull%0d: got %b want 0", i, rob_full); end
            alloc(1'b1, 6'(16 + i));
        end
        n_cmp++; if (rob_full !== 1'b1) begin n_err++; $display("FAIL fw_full: got %b want 1", rob_full); end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL fw_ready: got %b want 0", alloc_ready); end
        n_cmp++; if (rob_empty !== 1'b0) begin n_err++; $display("FAIL fw_empty: got %b want 0", rob_empty); end
        alloc(1'b1, 6'd63);
        n_cmp++; if (alloc_rob_id !== 4'd0) begin n_err++; $display("FAIL fw_17th_id: got %0d want 0", alloc_rob_id); end
        n_cmp++; if (rob_full !== 1'b1) begin n_err++; $display("FAIL fw_17th_full: got %b want 1", rob_full); end
        wb(4'd0);
        n_cmp++; if (commited_wr_register !== 6'd16) begin n_err++; $display("FAIL fw_commit0_reg: got %0d want 16", commited_wr_register); end
        // Full with a commit pending: allocation still refused this cycle.
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL fw_full_commit_ready: got %b want 0", alloc_ready); end
        tick();
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL fw_ready_after: got %b want 1", alloc_ready); end
        n_cmp++; if (alloc_rob_id !== 4'd0) begin n_err++; $display("FAIL fw_wrap_id: got %0d want 0", alloc_rob_id); end
        alloc(1'b1, 6'd50);
        n_cmp++; if (rob_full !== 1'b1) begin n_err++; $display("FAIL fw_refull: got %b want 1", rob_full); end
        n_cmp++; if (alloc_rob_id !== 4'd1) begin n_err++; $display("FAIL fw_tail1: got %0d want 1", alloc_rob_id); end
        wb(4'd1);
        n_cmp++; if (commited_wr_register !== 6'd17) begin n_err++; $display("FAIL fw_commit1_reg: got %0d want 17", commited_wr_register); end
    endtask

    task automatic test_no_write();
        do_reset();
        alloc(1'b0, 6'd40);
        wb(4'd0);
        n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL nw_cv: got %b want 1", commit_valid); end
        n_cmp++; if (commit_with_write !== 1'b0) begin n_err++; $display("FAIL nw_cww: got %b want 0", commit_with_write); end
        n_cmp++; if (commited_wr_register !== 6'd0) begin n_err++; $display("FAIL nw_reg: got %0d want 0", commited_wr_register); end
        tick();
        n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL nw_empty: got %b want 1", rob_empty); end
    endtask

    task automatic test_latency_ignore();
        do_reset();
        wb(4'd5);
        wb(4'd0);
        n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL li_empty: got %b want 1", rob_empty); end
        n_cmp++; if (alloc_rob_id !== 4'd0) begin n_err++; $display("FAIL li_id: got %0d want 0", alloc_rob_id); end
        alloc(1'b1, 6'd7);
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL li_stale_done: got %b want 0", commit_valid); end
        wb_valid = 1'b1; wb_rob_id = 4'd0;
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL li_cycleN: got %b want 0", commit_valid); end
        tick();
        wb_valid = 1'b0;
        n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL li_cycleN1: got %b want 1", commit_valid); end
        n_cmp++; if (commited_wr_register !== 6'd7) begin n_err++; $display("FAIL li_reg: got %0d want 7", commited_wr_register); end
        tick();
    endtask

    task automatic fill_six();
        for (int i = 0; i < 6; i++) alloc(1'b1, 6'(20 + i));
        wb(4'd1);
        wb(4'd2);
        wb(4'd0);
    endtask

    task automatic test_flush();
        do_reset();
        fill_six();
        flush = 1'b1; alloc_valid = 1'b1; alloc_with_write = 1'b1; alloc_phy_wr_reg = 6'd55;
        n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL fl_cv_pre: got %b want 1", commit_valid); end
        n_cmp++; if (commited_wr_register !== 6'd20) begin n_err++; $display("FAIL fl_reg_pre: got %0d want 20", commited_wr_register); end
        tick();
        idle();
        n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL fl_empty: got %b want 1", rob_empty); end
        n_cmp++; if (alloc_rob_id !== 4'd0) begin n_err++; $display("FAIL fl_tail: got %0d want 0", alloc_rob_id); end
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL fl_cv_post: got %b want 0", commit_valid); end
        alloc(1'b1, 6'd9);
        alloc(1'b1, 6'd10);
        alloc(1'b1, 6'd11);
        // Entry 2 was done before the flush; it must come back not-done.
        wb(4'd0);
        wb_valid = 1'b1; wb_rob_id = 4'd1;
        n_cmp++; if (commited_wr_register !== 6'd9) begin n_err++; $display("FAIL fl_reuse_reg: got %0d want 9", commited_wr_register); end
        tick();
        wb_valid = 1'b0;
        n_cmp++; if (commited_wr_register !== 6'd10) begin n_err++; $display("FAIL fl_reuse_reg1: got %0d want 10", commited_wr_register); end
        tick();
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL fl_done_cleared: got %b want 0", commit_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        fill_six();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL ar_cv: got %b want 0", commit_valid); end
        n_cmp++; if (commit_with_write !== 1'b0) begin n_err++; $display("FAIL ar_cww: got %b want 0", commit_with_write); end
        n_cmp++; if (commited_wr_register !== 6'd0) begin n_err++; $display("FAIL ar_reg: got %0d want 0", commited_wr_register); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready: got %b want 1", alloc_ready); end
        n_cmp++; if (alloc_rob_id !== 4'd0) begin n_err++; $display("FAIL ar_id: got %0d want 0", alloc_rob_id); end
        n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL ar_empty: got %b want 1", rob_empty); end
        n_cmp++; if (rob_full !== 1'b0) begin n_err++; $display("FAIL ar_full: got %b want 0", rob_full); end
        tick();
        reset = 1'b0;
        alloc(1'b1, 6'd3);
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL ar_done_cleared: got %b want 0", commit_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc(1'b1, 6'd10);
        alloc(1'b1, 6'd11);
        wb(4'd0);
        alloc_valid = 1'b1; alloc_with_write = 1'b1; alloc_phy_wr_reg = 6'd12;
        wb_valid = 1'b1; wb_rob_id = 4'd1;
        n_cmp++; if (commited_wr_register !== 6'd10) begin n_err++; $display("FAIL bb_reg0: got %0d want 10", commited_wr_register); end
        tick();
        idle();
        n_cmp++; if (commited_wr_register !== 6'd11) begin n_err++; $display("FAIL bb_reg1: got %0d want 11", commited_wr_register); end
        n_cmp++; if (alloc_rob_id !== 4'd3) begin n_err++; $display("FAIL bb_tail: got %0d want 3", alloc_rob_id); end
        tick();
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL bb_head2_notdone: got %b want 0", commit_valid); end
        n_cmp++; if (rob_empty !== 1'b0) begin n_err++; $display("FAIL bb_notempty: got %b want 0", rob_empty); end
        wb(4'd2);
        n_cmp++; if (commited_wr_register !== 6'd12) begin n_err++; $display("FAIL bb_reg2: got %0d want 12", commited_wr_register); end
        tick();
        n_cmp++; if (rob_empty !== 1'b1) begin n_err++; $display("FAIL bb_empty: got %b want 1", rob_empty); end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #1;
        test_reset();
        test_in_order();
        test_full_wrap();
        test_no_write();
        test_latency_ignore();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
